// File: rtl/issue_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : issue_scoreboard_pkg
// Purpose  : Shared constants and helpers for the in-order issue scoreboard.
//            Holds the register-index width, the hard-wired zero register
//            number and the default in-flight limit.
// Ports    : (package - no ports)
// Revision : 1.0  initial release
// ============================================================================
package issue_scoreboard_pkg;

  // Register file geometry: 32 architectural registers, 5-bit index.
  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_REGS = 1 << REG_W;

  // r0 is hard-wired to zero and is never tracked.
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Default limit on issued-but-not-written-back instructions (legal 1..7).
  localparam int unsigned MAX_INFLIGHT_DEF = 4;

  // Width of the in-flight counter; wide enough for the largest legal limit.
  localparam int unsigned CNT_W = 3;

  // One-hot decode of a register number into a per-register vector.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage : issue_scoreboard_pkg
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : issue_scoreboard
// Purpose  : Register busy-bit scoreboard for an in-order pipeline. Tracks
//            which destination registers have an outstanding writer, stalls
//            decode on RAW/WAW hazards or when the in-flight limit is hit,
//            and releases the stall in the same cycle as the clearing
//            writeback (register bank is write-through).
// Ports    :
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous active-low reset
//   d_valid   in   1   decode holds an instruction requesting issue
//   d_rs      in   5   source A register
//   d_rt      in   5   source B register
//   d_rd      in   5   destination register
//   d_use_rs  in   1   source A is read
//   d_use_rt  in   1   source B is read
//   d_writes  in   1   instruction writes d_rd
//   wb_valid  in   1   writeback completes this cycle
//   wb_reg    in   5   register being written back
//   flush     in   1   synchronous discard of all in-flight tracking
//   stall     out  1   combinational stall to Fetch and IF/ID
//   issue     out  1   combinational issue strobe
//   pending   out  32  registered per-register busy vector
//   inflight  out  3   registered count of tracked writers
//   err       out  1   sticky flag: writeback to a register not pending
// Revision : 1.0  initial release
// ============================================================================
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  // Legal range 1..7 (inflight is 3 bits wide).
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_valid,
  input  logic [REG_W-1:0]    d_rs,
  input  logic [REG_W-1:0]    d_rt,
  input  logic [REG_W-1:0]    d_rd,
  input  logic                d_use_rs,
  input  logic                d_use_rt,
  input  logic                d_writes,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_reg,
  input  logic                flush,
  output logic                stall,
  output logic                issue,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    inflight,
  output logic                err
);

  localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_INFLIGHT);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NUM_REGS-1:0] pending_q,  pending_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic                err_q,      err_d;

  // --------------------------------------------------------------------------
  // Hazard evaluation
  // --------------------------------------------------------------------------
  logic [NUM_REGS-1:0] wb_onehot;   // register named by an active writeback
  logic [NUM_REGS-1:0] hazard_vec;  // busy and not being released this cycle
  logic                wb_hit;      // writeback retires a tracked writer
  logic                wb_stray;    // writeback to a register not pending
  logic                raw_haz;
  logic                waw_haz;
  logic                full;
  logic                alloc;       // issue that claims a destination
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  always_comb begin
    wb_onehot  = wb_valid ? reg_onehot(wb_reg) : '0;
    wb_hit     = wb_valid &  pending_q[wb_reg];
    wb_stray   = wb_valid & ~pending_q[wb_reg];

    // The register bank forwards the writeback value in the same cycle, so a
    // register being written back is already safe to read or overwrite.
    // r0 is never set in pending_q, so it can never appear hazardous.
    hazard_vec = pending_q & ~wb_onehot;

    raw_haz    = (d_use_rs & hazard_vec[d_rs]) | (d_use_rt & hazard_vec[d_rt]);
    waw_haz    = d_writes & hazard_vec[d_rd];

    // A retiring writer frees its slot in time for the new one.
    full       = (inflight_q == c_MAX_CNT) & ~wb_hit;

    // Flush squashes whatever decode holds, so it must neither stall nor issue.
    stall      = d_valid & (raw_haz | waw_haz | full) & ~flush;
    issue      = d_valid & ~stall & ~flush;

    // Only instructions that really produce a register value are tracked;
    // stores, branches, nops and writes to r0 need no writeback retire.
    alloc      = issue & d_writes & (d_rd != REG_ZERO);
    set_vec    = alloc  ? reg_onehot(d_rd)   : '0;
    clr_vec    = wb_hit ? reg_onehot(wb_reg) : '0;
  end

  // --------------------------------------------------------------------------
  // Next-state
  // --------------------------------------------------------------------------
  always_comb begin
    pending_d  = pending_q;
    inflight_d = inflight_q;
    err_d      = err_q | wb_stray;

    if (flush) begin
      pending_d  = '0;
      inflight_d = '0;
    end else begin
      // Set is applied after clear: a same-cycle new writer of the register
      // being retired keeps the bit busy. Bit 0 is masked for robustness.
      pending_d = ((pending_q & ~clr_vec) | set_vec) & ~reg_onehot(REG_ZERO);

      // Simultaneous allocate and retire leave the count unchanged. The
      // bounds guards keep the counter inside 0..MAX_INFLIGHT.
      if (alloc && !wb_hit) begin
        if (inflight_q != c_MAX_CNT) begin
          inflight_d = inflight_q + CNT_W'(1);
        end
      end else if (!alloc && wb_hit) begin
        if (inflight_q != '0) begin
          inflight_d = inflight_q - CNT_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign pending  = pending_q;
  assign inflight = inflight_q;
  assign err      = err_q;

endmodule : issue_scoreboard
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_scoreboard
// Purpose  : Self-checking bench for issue_scoreboard. Each stimulus cycle
//            pushes its hand-computed expected outputs into a queue; a monitor
//            on the falling edge pops one entry per cycle and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        d_valid = 1'b0;
  logic [4:0]  d_rs = '0, d_rt = '0, d_rd = '0;
  logic        d_use_rs = 1'b0, d_use_rt = 1'b0, d_writes = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic        flush = 1'b0;
  logic        stall, issue, err;
  logic [31:0] pending;
  logic [2:0]  inflight;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        stall;
    logic        issue;
    logic [31:0] pend;
    logic [2:0]  infl;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  issue_scoreboard #(.MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_writes(d_writes),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
    .stall(stall), .issue(issue), .pending(pending),
    .inflight(inflight), .err(err)
  );

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, act, want);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "stall",    {31'd0, stall}, {31'd0, e.stall});
        chk(e.name, "issue",    {31'd0, issue}, {31'd0, e.issue});
        chk(e.name, "pending",  pending,        e.pend);
        chk(e.name, "inflight", {29'd0, inflight}, {29'd0, e.infl});
        chk(e.name, "err",      {31'd0, err},   {31'd0, e.err});
      end
    end
  end

  // One cycle of stimulus plus its expected outputs. Inputs change 1 ns after
  // the rising edge; the expectation describes the state seen in this cycle.
  task automatic step(input string name, input logic r,
                      input logic dv, input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt,
                      input logic [4:0] rd, input logic wr,
                      input logic wv, input logic [4:0] wr_reg, input logic fl,
                      input logic e_stall, input logic e_issue,
                      input logic [31:0] e_pend, input logic [2:0] e_infl,
                      input logic e_err);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; d_valid = dv; d_rs = rs; d_use_rs = urs; d_rt = rt; d_use_rt = urt;
    d_rd = rd; d_writes = wr; wb_valid = wv; wb_reg = wr_reg; flush = fl;
    e.name = name; e.stall = e_stall; e.issue = e_issue;
    e.pend = e_pend; e.infl = e_infl; e.err = e_err;
    exp_q.push_back(e);
  endtask

  initial begin
    //    name        rst dv rs urs rt urt rd wr wv wbr fl | stall issue pend  infl err
    step("reset",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,    0, 0);
    step("idle0",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,    0, 0);
    // RAW on r10 released in the writeback cycle
    step("addi_r10",   1, 1, 0, 0, 0, 0,10, 1, 0, 0, 0,   0, 1, 32'h0,    0, 0);
    step("raw_stall1", 1, 1,10, 1,11, 1,12, 1, 0, 0, 0,   1, 0, 32'h400,  1, 0);
    step("raw_stall2", 1, 1,10, 1,11, 1,12, 1, 0, 0, 0,   1, 0, 32'h400,  1, 0);
    step("raw_wb_rel", 1, 1,10, 1,11, 1,12, 1, 1,10, 0,   0, 1, 32'h400,  1, 0);
    step("wb_r12",     1, 0, 0, 0, 0, 0, 0, 0, 1,12, 0,   0, 0, 32'h1000, 1, 0);
    // Fill to the limit, then full release by a same-cycle writeback
    step("iss_r1",     1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 1, 32'h0,    0, 0);
    step("iss_r2",     1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0,   0, 1, 32'h2,    1, 0);
    step("iss_r3",     1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   0, 1, 32'h6,    2, 0);
    step("iss_r4",     1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0,   0, 1, 32'hE,    3, 0);
    step("full_r5",    1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   1, 0, 32'h1E,   4, 0);
    step("full_wb_r1", 1, 1, 0, 0, 0, 0, 5, 1, 1, 1, 0,   0, 1, 32'h1E,   4, 0);
    step("wb_r2",      1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0,   0, 0, 32'h3C,   4, 0);
    // Same-cycle set and clear of r7: set wins, count unchanged
    step("iss_r7",     1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,   0, 1, 32'h38,   3, 0);
    step("waw_wb_r7",  1, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0,   0, 1, 32'hB8,   4, 0);
    step("keep_r7",    1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'hB8,   4, 0);
    // Stray writeback sets sticky err, state untouched
    step("stray_wb9",  1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0,   0, 0, 32'hB8,   4, 0);
    step("wb_r3",      1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,   0, 0, 32'hB8,   4, 1);
    // Flush with three in flight, overriding issue and writeback
    step("flush",      1, 1, 0, 0, 0, 0, 8, 1, 1, 4, 1,   0, 0, 32'hB0,   3, 1);
    step("post_flush", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,    0, 1);
    // r0 never hazards or tracks; non-writers are not counted
    step("r0_src_dst", 1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0,   0, 1, 32'h0,    0, 1);
    step("nonwriter",  1, 1, 0, 0, 0, 0, 6, 0, 0, 0, 0,   0, 1, 32'h0,    0, 1);
    step("idle_r0",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,    0, 1);
    // Two in flight, then asynchronous reset mid-cycle
    step("iss2_r1",    1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 1, 32'h0,    0, 1);
    step("iss2_r2",    1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0,   0, 1, 32'h2,    1, 1);
    step("pre_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h6,    2, 1);
    step("async_rst",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,    0, 0);
    step("rst_rel",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,    0, 0);
    // Stale writeback after reset restart
    step("stale_wb1",  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   0, 0, 32'h0,    0, 0);
    step("stale_err",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,    0, 1);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_issue_scoreboard
`default_nettype wire
